data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 19 +
 rtl/data_cache_if.sv | 28 ++
 rtl/data_cache_store.sv | 47 ++++
 rtl/data_cache.sv | 128 ++++++++++++
 tb/tb_data_cache.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    WRITE_THRU = 2'd2
  } state_t;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  // Byte offset is always two bits because lines hold a single 32-bit-aligned word.
  function automatic int tag_width(input int addr_width, input int sets);
    return addr_width - 2 - $clog2(sets);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side bus bundle for data_cache; slave is the cache, master the environment.
interface data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic [DATA_WIDTH-1:0] cpu_rdata_o;
  logic                  cpu_stall_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/data_cache_store.sv
// Line storage: valid/tag/data arrays with one combinational read port and one synchronous write port.
module cache_store
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  localparam int IDX_W     = index_width(SETS),
  localparam int TAG_W     = tag_width(ADDR_WIDTH, SETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tags  [SETS];
  logic [DATA_WIDTH-1:0] words [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache with a stalling CPU port.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  data_cache_if.slave  bus
);

  localparam int IDX_W = index_width(SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);

  state_t                state;
  logic                  mem_req;
  logic                  mem_we;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;
  logic                  acked;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  stall;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_offset;

  assign idx           = bus.cpu_addr_i[IDX_W+1:2];
  assign tag           = bus.cpu_addr_i[ADDR_WIDTH-1:IDX_W+2];
  assign unused_offset = ^bus.cpu_addr_i[1:0];

  cache_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SETS       (SETS)
  ) u_store (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  assign hit   = bus.cpu_req_i & line_valid & (line_tag == tag);
  // An ack only counts while a memory request is actually outstanding.
  assign acked = bus.mem_ack_i & mem_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_i && bus.cpu_we_i) begin
            state   <= WRITE_THRU;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (bus.cpu_req_i && !hit) begin
            state   <= REFILL;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end
        end
        REFILL, WRITE_THRU: begin
          if (acked) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall   = 1'b0;
    rdata   = '0;
    wr_en   = 1'b0;
    wr_data = bus.cpu_wdata_i;
    case (state)
      IDLE: begin
        stall = bus.cpu_req_i & (bus.cpu_we_i | ~hit);
        if (hit && !bus.cpu_we_i) rdata = line_data;
      end
      REFILL: begin
        stall   = ~acked;
        wr_en   = acked;
        wr_data = bus.mem_rdata_i;
        if (acked) rdata = bus.mem_rdata_i;
      end
      WRITE_THRU: begin
        stall = ~acked;
        wr_en = acked & hit;
      end
      default: ;
    endcase
    if (rst_i) begin
      stall = 1'b0;
      rdata = '0;
    end
  end

  // CPU holds its request while stalled, so address and write data stay stable on the memory bus.
  assign bus.cpu_stall_o = stall;
  assign bus.cpu_rdata_o = rdata;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = {bus.cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata_o = bus.cpu_wdata_i;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays CPU and main memory with programmable ack delay.
module tb_data_cache;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  data_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Runs one CPU access from posedge+1 until the stall drops, acting as memory; reports observations.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_delay, input logic [31:0] mdata,
                        output int stalls, output logic [31:0] rdata, output logic saw_req,
                        output logic saw_we, output logic [31:0] saw_addr,
                        output logic [31:0] saw_wdata, output logic stable);
    int reqc;
    bit done;
    stalls = 0; rdata = '0; saw_req = 0; saw_we = 0; saw_addr = '0; saw_wdata = '0;
    stable = 1; reqc = 0; done = 0;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wdata;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus.mem_req_o === 1'b1) begin
        if (!saw_req) begin
          saw_req = 1; saw_we = bus.mem_we_o; saw_addr = bus.mem_addr_o; saw_wdata = bus.mem_wdata_o;
        end else if (bus.mem_we_o !== saw_we || bus.mem_addr_o !== saw_addr ||
                     bus.mem_wdata_o !== saw_wdata) begin
          stable = 0;
        end
        if (reqc == ack_delay) begin
          bus.mem_ack_i = 1'b1; bus.mem_rdata_i = mdata;
        end
        reqc++;
      end
      #1;
      if (bus.cpu_stall_o === 1'b0) begin
        done = 1; rdata = bus.cpu_rdata_o;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL access_timeout addr=%h stall still high after 40 cycles", addr);
    end
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h40;
    @(negedge clk);
    checks++; if (bus.cpu_stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we_o); end
    checks++; if (bus.cpu_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.cpu_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_req_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored mem_req got=%b exp=0", bus.mem_req_o); end
    checks++; if (bus.cpu_stall_o !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", bus.cpu_stall_o); end
    checks++; if (bus.cpu_rdata_o !== 32'h0) begin failures++; $display("FAIL idle_rdata got=%h exp=0", bus.cpu_rdata_o); end
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_load_miss_refill();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    access(1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, s, rd, r, w, a, wd, st);
    checks++; if (s != 3) begin failures++; $display("FAIL miss_stalls got=%0d exp=3", s); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL miss_rdata got=%h exp=deadbeef", rd); end
    checks++; if (r !== 1'b1 || w !== 1'b0 || a !== 32'h40) begin failures++; $display("FAIL miss_mem_req req=%b we=%b addr=%h exp 1/0/00000040", r, w, a); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL miss_bus_stable got=%b exp=1", st); end
    access(1'b0, 32'h40, 32'h0, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (s != 0 || r !== 1'b0) begin failures++; $display("FAIL hit_stalls stalls=%0d req=%b exp 0/0", s, r); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL hit_rdata got=%h exp=deadbeef", rd); end
    @(negedge clk);
    checks++; if (bus.cpu_rdata_o !== 32'h0) begin failures++; $display("FAIL idle_after_hit_rdata got=%h exp=0", bus.cpu_rdata_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_hit();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    access(1'b1, 32'h40, 32'hCAFEF00D, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (s != 1) begin failures++; $display("FAIL store_stalls got=%0d exp=1", s); end
    checks++; if (w !== 1'b1 || a !== 32'h40 || wd !== 32'hCAFEF00D) begin failures++; $display("FAIL store_bus we=%b addr=%h wdata=%h exp 1/00000040/cafef00d", w, a, wd); end
    access(1'b0, 32'h40, 32'h0, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (s != 0 || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL store_hit_update stalls=%0d rdata=%h exp 0/cafef00d", s, rd); end
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    access(1'b1, 32'h80, 32'h11111111, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (s != 1 || a !== 32'h80) begin failures++; $display("FAIL store_miss stalls=%0d addr=%h exp 1/00000080", s, a); end
    access(1'b0, 32'h80, 32'h0, 1, 32'h22222222, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || w !== 1'b0 || a !== 32'h80) begin failures++; $display("FAIL no_alloc_refill req=%b we=%b addr=%h exp 1/0/00000080", r, w, a); end
    checks++; if (s != 2 || rd !== 32'h22222222) begin failures++; $display("FAIL no_alloc_data stalls=%0d rdata=%h exp 2/22222222", s, rd); end
  endtask

  task automatic test_alias();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    access(1'b0, 32'h40, 32'h0, 0, 32'hA0A0A0A0, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || s != 1 || rd !== 32'hA0A0A0A0) begin failures++; $display("FAIL alias_40_miss req=%b stalls=%0d rdata=%h exp 1/1/a0a0a0a0", r, s, rd); end
    access(1'b0, 32'h80, 32'h0, 0, 32'hB0B0B0B0, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || a !== 32'h80) begin failures++; $display("FAIL alias_80_miss req=%b addr=%h exp 1/00000080", r, a); end
    access(1'b0, 32'h40, 32'h0, 0, 32'hC0C0C0C0, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || a !== 32'h40) begin failures++; $display("FAIL alias_40_remiss req=%b addr=%h exp 1/00000040", r, a); end
    access(1'b0, 32'h40, 32'h0, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b0 || rd !== 32'hC0C0C0C0) begin failures++; $display("FAIL alias_refilled_hit req=%b rdata=%h exp 0/c0c0c0c0", r, rd); end
  endtask

  task automatic test_reset_mid_refill();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h104;
    @(negedge clk);
    checks++; if (bus.cpu_stall_o !== 1'b1) begin failures++; $display("FAIL midrst_idle_stall got=%b exp=1", bus.cpu_stall_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h104) begin failures++; $display("FAIL midrst_refill req=%b addr=%h exp 1/00000104", bus.mem_req_o, bus.mem_addr_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin failures++; $display("FAIL midrst_drop req=%b stall=%b exp 0/0", bus.mem_req_o, bus.cpu_stall_o); end
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b0) begin failures++; $display("FAIL late_ack_ignored mem_req got=%b exp=0", bus.mem_req_o); end
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    access(1'b0, 32'h40, 32'h0, 0, 32'h55550040, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || s != 1) begin failures++; $display("FAIL postrst_40_miss req=%b stalls=%0d exp 1/1", r, s); end
    access(1'b0, 32'h104, 32'h0, 0, 32'h55550104, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || rd !== 32'h55550104) begin failures++; $display("FAIL postrst_104_miss req=%b rdata=%h exp 1/55550104", r, rd); end
  endtask

  task automatic test_unaligned();
    int s; logic [31:0] rd, a, wd; logic r, w, st;
    access(1'b0, 32'h43, 32'h0, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (s != 0 || rd !== 32'h55550040) begin failures++; $display("FAIL unaligned_hit stalls=%0d rdata=%h exp 0/55550040", s, rd); end
    access(1'b1, 32'h43, 32'h0BADF00D, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (a !== 32'h40 || w !== 1'b1) begin failures++; $display("FAIL unaligned_store addr=%h we=%b exp 00000040/1", a, w); end
    access(1'b0, 32'h40, 32'h0, 0, 32'h0, s, rd, r, w, a, wd, st);
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL unaligned_store_data got=%h exp=0badf00d", rd); end
    access(1'b0, 32'h147, 32'h0, 0, 32'h77777777, s, rd, r, w, a, wd, st);
    checks++; if (r !== 1'b1 || a !== 32'h144) begin failures++; $display("FAIL unaligned_refill req=%b addr=%h exp 1/00000144", r, a); end
  endtask

  initial begin
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ack_i = 1'b0;
    test_reset();
    test_load_miss_refill();
    test_store_hit();
    test_store_miss();
    test_alias();
    test_reset_mid_refill();
    test_unaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
